dequant_unit: RTL
=================

DEQUANT_UNIT -- requirements
Module: dequant_unit

Interface
REQ-001 The module SHALL have parameter IMG_W, default 28, pixels per row.
REQ-002 The module SHALL have parameter IMG_H, default 28, rows per frame.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1, input sample valid.
REQ-006 The module SHALL have port in_ready, output, 1, unit accepts a sample this cycle.
REQ-007 The module SHALL have port q_in, input, 8, signed quantized pixel (-128..127).
REQ-008 The module SHALL have port out_valid, output, 1, output pixel valid.
REQ-009 The module SHALL have port out_ready, input, 1, downstream accepts the pixel.
REQ-010 The module SHALL have port pix_out, output, 8, unsigned restored pixel (0..255).
REQ-011 The module SHALL have ports sof, eol and eof, output, 1 each, qualified by out_valid: first pixel of frame, last pixel of row, last pixel of frame.
REQ-012 The module SHALL have port sat, output, 1, qualified by out_valid: the pixel was clamped.

Function
REQ-013 The arithmetic SHALL be as follows.
- u = q_in + 19, signed, 9 bits.
- If u < 0, p = 0 and sat = 1.
- Otherwise p = (u*446 + 128) >> 8 in at least 17 bits.
- If p > 255, the output SHALL be 255 and sat = 1.
REQ-014 The datapath SHALL be two pipeline stages.
- Stage 1 registers u and the multiply.
- Stage 2 registers the round, clamp and flags.
- Latency from input handshake to out_valid SHALL be 2 cycles when not stalled.
REQ-015 The stall rule SHALL be as follows.
- Pipeline enable en = !out_valid || out_ready.
- in_ready SHALL equal en (combinational).
- Both stages SHALL hold all contents while en = 0.
REQ-016 An input handshake SHALL occur when in_valid && in_ready; a stage-1 bubble SHALL propagate as out_valid = 0.
REQ-017 Once asserted, out_valid, pix_out and the flags SHALL stay stable until out_ready is sampled high.
REQ-018 Position counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on input handshake.
- col SHALL wrap to 0 and row increment at col = IMG_W-1.
- Both SHALL wrap to 0 at the last pixel.
- Flags SHALL be computed from the counters at handshake and pipelined with the data.
REQ-019 sof SHALL be 1 iff col = 0 and row = 0; eol SHALL be 1 iff col = IMG_W-1; eof SHALL be 1 iff eol and row = IMG_H-1.
REQ-020 Back-to-back frames SHALL need no idle cycles; the first pixel after eof SHALL carry sof.
REQ-021 Full throughput, one pixel per cycle, SHALL be sustained while out_ready = 1.

Reset
REQ-022 On rst = 1 at a clock edge, the following SHALL apply.
- Outputs: out_valid = 0, pix_out = 0, sof/eol/eof/sat = 0.
- Both stage valids SHALL be cleared.
- col = 0 and row = 0.
REQ-023 Reset asserted mid-frame SHALL discard in-flight pixels and restart counting, so the next accepted pixel is sof.
REQ-024 in_ready SHALL be 1 during and after reset, since out_valid = 0.

Configuration
REQ-025 With DEQUANT_SAT_CNT_EN defined, the following SHALL apply.
- An extra output sat_cnt (16-bit, unsigned, saturating at 0xFFFF) SHALL be present.
- It SHALL count output handshakes with sat = 1.
- It SHALL clear on rst and on an output handshake carrying sof.
REQ-026 Without DEQUANT_SAT_CNT_EN, the sat_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Shared package cnn_pkg SHALL hold the constants ZERO_POINT = 19, DEQ_MULT = 446, DEQ_SHIFT = 8 and the IMG_W/IMG_H defaults, shared with the input quantizer.
REQ-028 The arithmetic of REQ-013 SHALL be a sub-module dequant_core: a two-stage registered datapath with an enable input; dequant_unit owns the handshake, counters and flags.

Verification
REQ-029 Arithmetic, with out_ready = 1: q_in = -19, 0, 100 and 127 SHALL give pix_out = 0, 33, 207 and 254 respectively, each with sat = 0 and 2-cycle latency.
REQ-030 Saturation: q_in = -128 -> pix_out = 0, sat = 1; q_in = -20 -> pix_out = 0, sat = 1.
REQ-031 Frame flags: 784 continuous pixels, then 1 more.
- Output 0 carries sof.
- Outputs 27, 55, ... carry eol.
- Output 783 carries eol and eof.
- Output 784 carries sof.
REQ-032 Backpressure: out_ready held 0 for 5 cycles with in_valid = 1 -> in_ready = 0; out_valid and data stable; no pixel lost or duplicated after release.
REQ-033 Reset mid-operation: rst pulsed at pixel 300 -> out_valid = 0 next cycle; the next accepted pixel emerges with sof = 1.
REQ-034 With DEQUANT_SAT_CNT_EN: a frame containing 3 inputs of -128 -> sat_cnt = 3 at eof; sat_cnt = 0 after the next sof handshake.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants: zero point, dequantisation scale and
// default image geometry. Shared with the input quantizer so both ends of
// the quantise/dequantise path always agree.
package cnn_pkg;

    localparam int ZERO_POINT = 19;
    localparam int DEQ_MULT   = 446;
    localparam int DEQ_SHIFT  = 8;
    localparam int DEQ_ROUND  = 1 << (DEQ_SHIFT - 1);

    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;

    // u is at most 255 and DEQ_MULT fits in 9 bits, so the product fits in 17 bits
    localparam int PROD_W     = 17;

endpackage

// File: rtl/dequant_core.sv
// Two-stage dequantisation datapath.
// Stage 1 removes the zero point and multiplies by the scale.
// Stage 2 rounds, shifts and clamps to 0..255, and raises sat when it clamps.
// Both stages advance only while en is high. Control bits (valid, position
// flags) are carried alongside by the caller.
module dequant_core
    import cnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] q_in,
    output logic [7:0] pix_out,
    output logic       sat
);

    logic [8:0]        w_u;
    logic [PROD_W-1:0] w_rnd;
    logic [PROD_W-1:0] w_p;

    logic              r_neg;
    logic [PROD_W-1:0] r_prod;

    // Sign-extend q_in to 9 bits and add the zero point; wraps as two's complement.
    assign w_u   = {q_in[7], q_in} + 9'(ZERO_POINT);
    assign w_rnd = r_prod + PROD_W'(DEQ_ROUND);
    assign w_p   = w_rnd >> DEQ_SHIFT;

    // Stage 1: remember the sign of u and register the product of its magnitude bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg  <= 1'b0;
            r_prod <= '0;
        end else if (en) begin
            r_neg  <= w_u[8];
            r_prod <= PROD_W'(w_u[7:0]) * PROD_W'(DEQ_MULT);
        end
    end

    // Stage 2: round and clamp; a negative u gives 0 and a result above 255 gives 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out <= 8'd0;
            sat     <= 1'b0;
        end else if (en) begin
            if (r_neg) begin
                pix_out <= 8'd0;
                sat     <= 1'b1;
            end else if (w_p[PROD_W-1:8] != '0) begin
                pix_out <= 8'hFF;
                sat     <= 1'b1;
            end else begin
                pix_out <= w_p[7:0];
                sat     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dequant_unit.sv
// Streaming pixel dequantiser with valid/ready handshakes on both sides.
// The unit owns the handshake, the row/column counters and the frame flags.
// The flags are captured when a pixel is accepted and travel down the
// two-stage pipeline in step with the data produced by dequant_core.
// Optional feature: define DEQUANT_SAT_CNT_EN to add sat_cnt, a saturating
// count of clamped pixels output since the last start of frame.
module dequant_unit
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  q_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  pix_out,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic        sat
`ifdef DEQUANT_SAT_CNT_EN
    ,
    output logic [15:0] sat_cnt
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic          w_en;
    logic          w_in_hs;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_sof;
    logic          w_eol;
    logic          w_eof;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_s1_valid, r_s1_sof, r_s1_eol, r_s1_eof;
    logic          r_s2_valid, r_s2_sof, r_s2_eol, r_s2_eof;

    // The pipeline moves whenever the output register is empty or being drained.
    assign w_en       = !r_s2_valid || out_ready;
    assign in_ready   = w_en;
    assign w_in_hs    = in_valid && w_en;

    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_row = (r_row == RW'(IMG_H - 1));
    assign w_sof      = (r_col == '0) && (r_row == '0);
    assign w_eol      = w_last_col;
    assign w_eof      = w_last_col && w_last_row;

    dequant_core u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (w_en),
        .q_in    (q_in),
        .pix_out (pix_out),
        .sat     (sat)
    );

    // Position counters step once per accepted pixel and wrap at the end of each row and frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_hs) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Valid bits and position flags travel alongside the datapath; an idle input cycle becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_eol   <= 1'b0;
            r_s2_eof   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_sof   <= w_sof;
            r_s1_eol   <= w_eol;
            r_s1_eof   <= w_eof;
            r_s2_valid <= r_s1_valid;
            r_s2_sof   <= r_s1_valid && r_s1_sof;
            r_s2_eol   <= r_s1_valid && r_s1_eol;
            r_s2_eof   <= r_s1_valid && r_s1_eof;
        end
    end

    assign out_valid = r_s2_valid;
    assign sof       = r_s2_sof;
    assign eol       = r_s2_eol;
    assign eof       = r_s2_eof;

`ifdef DEQUANT_SAT_CNT_EN
    logic w_out_hs;
    assign w_out_hs = r_s2_valid && out_ready;

    // Clamp counter restarts when a start-of-frame pixel leaves and sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= 16'd0;
        end else if (w_out_hs) begin
            if (r_s2_sof) begin
                sat_cnt <= 16'd0;
            end else if (sat && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
